// File: rtl/past_assert_feeder_if.sv
// Request, downstream-start and status signals of the PastAssert feeder.
// master: the side that issues requests and models the downstream stage.
// slave:  the feeder itself.
interface past_assert_feeder_if #(
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int TOTAL_WIDTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                   request__ENA;
    logic [CNT_WIDTH-1:0]   request_count;
    logic                   request__RDY;
    logic                   startSignal__ENA;
    logic                   startSignal__RDY;
    logic                   busy;
    logic                   done__ENA;
    logic                   clearError__ENA;
    logic                   error;
    logic [LVL_W-1:0]       level;
    logic [TOTAL_WIDTH-1:0] issued_total;

    modport master (
        output request__ENA, request_count, startSignal__RDY, busy, clearError__ENA,
        input  request__RDY, startSignal__ENA, done__ENA, error, level, issued_total
    );

    modport slave (
        input  request__ENA, request_count, startSignal__RDY, busy, clearError__ENA,
        output request__RDY, startSignal__ENA, done__ENA, error, level, issued_total
    );
endinterface

// File: rtl/past_assert_feeder.sv
// Upstream sequencer for the PastAssert countdown stage: queues repeat-count
// requests, issues one start per repetition, reports completion, and aborts
// a request whose downstream never returns to idle.
module past_assert_feeder #(
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int TIMEOUT     = 64,
    parameter int TOTAL_WIDTH = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    past_assert_feeder_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WC_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [WC_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [TOTAL_WIDTH-1:0] total_q, total_d;

    logic                   push;
    logic                   pop;
    logic                   start_fire;
    logic                   wait_ok;
    logic [CNT_WIDTH-1:0]   head_count;

    assign bus.request__RDY = (level_q != LVL_W'(DEPTH));
    assign push             = bus.request__ENA && bus.request__RDY;
    assign head_count       = mem_q[rd_ptr_q];

    // Start is decoded from state so it drops the instant reset asserts.
    assign start_fire           = (state_q == ISSUE) && bus.startSignal__RDY;
    assign bus.startSignal__ENA = start_fire;

    // The first WAIT cycle is skipped (downstream has not yet seen the start);
    // afterwards the downstream counts as finished once it reports idle and
    // not busy, which also covers a zero-length countdown where busy never rises.
    assign wait_ok = bus.startSignal__RDY && !bus.busy && (wait_cnt_q != '0);

    assign bus.done__ENA    = done_q;
    assign bus.error        = error_q;
    assign bus.level        = level_q;
    assign bus.issued_total = total_q;

    // Sequencer next-state: load head, issue starts, wait for completion or timeout.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        total_d     = total_q;
        done_d      = 1'b0;
        error_d     = error_q;
        pop         = 1'b0;

        if (bus.clearError__ENA) begin
            error_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                remaining_d = head_count;
                if (head_count == '0) begin
                    pop     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (start_fire) begin
                    total_d    = total_q + TOTAL_WIDTH'(1);
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
                if (wait_ok) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        pop     = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                    // Abort overrides a simultaneous clear.
                    error_d = 1'b1;
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; simultaneous push and pop keep level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.request_count;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            total_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= done_d;
            error_q     <= error_d;
            total_q     <= total_d;
        end
    end
endmodule

// File: tb/tb_past_assert_feeder.sv
// Scoreboard bench for past_assert_feeder with a MAX_AMOUNT=22 countdown model.
module tb_past_assert_feeder;
    localparam int MAX_AMOUNT = 22;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    int   cyc  = 0;

    int compared   = 0;
    int mismatched = 0;

    int exp_ena_q[$];
    int exp_done_q[$];
    int exp_total_q[$];

    int   ds_cnt   = 0;
    logic ds_stuck = 1'b0;

    past_assert_feeder_if #(.DEPTH(4), .CNT_WIDTH(8), .TOTAL_WIDTH(16)) bus ();

    past_assert_feeder #(
        .DEPTH(4), .CNT_WIDTH(8), .TIMEOUT(64), .TOTAL_WIDTH(16)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Downstream countdown model.
    always @(posedge CLK) begin
        if (bus.startSignal__ENA) ds_cnt <= MAX_AMOUNT;
        else if (ds_cnt != 0)     ds_cnt <= ds_cnt - 1;
    end
    assign bus.startSignal__RDY = (ds_cnt == 0) && !ds_stuck;
    assign bus.busy             = (ds_cnt != 0);

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT emits a start or a done.
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.startSignal__ENA) begin
                check("ena_rdy_high", bus.startSignal__RDY, 1);
                if (exp_ena_q.size() == 0) check("ena_unexpected_cycle", cyc, -1);
                else                       check("ena_cycle", cyc, exp_ena_q.pop_front());
            end
            if (bus.done__ENA) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected_cycle", cyc, -1);
                end else begin
                    check("done_cycle", cyc, exp_done_q.pop_front());
                    check("done_total", bus.issued_total, exp_total_q.pop_front());
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic goto(input int c);
        int n = 0;
        while (cyc < c && n < 10000) begin
            next_cycle();
            n++;
        end
    endtask

    task automatic at(input int c);
        goto(c);
        @(negedge CLK);
    endtask

    task automatic do_req(input int count, output int acc);
        bit ok = 1'b0;
        acc = cyc;
        bus.request__ENA  = 1'b1;
        bus.request_count = 8'(count);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (bus.request__RDY) begin
                ok  = 1'b1;
                acc = cyc;
            end
            next_cycle();
        end
        bus.request__ENA = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL req_accept: request__RDY stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic expect_ena(input int c);
        exp_ena_q.push_back(c);
    endtask

    task automatic expect_done(input int c, input int total);
        exp_done_q.push_back(c);
        exp_total_q.push_back(total);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, a, b, c, d, e;
        bus.request__ENA    = 1'b0;
        bus.request_count   = '0;
        bus.clearError__ENA = 1'b0;

        // Reset state
        #2 nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ena",   bus.startSignal__ENA, 0);
        check("rst_done",  bus.done__ENA, 0);
        check("rst_error", bus.error, 0);
        check("rst_level", bus.level, 0);
        check("rst_total", bus.issued_total, 0);
        check("rst_rdy",   bus.request__RDY, 1);
        next_cycle();
        nRST = 1'b1;
        next_cycle();
        next_cycle();

        // Single repetition: ENA at t+3, done at t+27
        do_req(1, t);
        expect_ena(t + 3);
        expect_done(t + 27, 1);
        at(t + 30);
        check("single_level", bus.level, 0);
        check("single_total", bus.issued_total, 1);
        next_cycle();

        // Three repetitions, 24 cycles apart, one done
        do_req(3, t);
        expect_ena(t + 3);
        expect_ena(t + 27);
        expect_ena(t + 51);
        expect_done(t + 75, 4);
        at(t + 78);
        check("triple_total", bus.issued_total, 4);
        next_cycle();

        // Zero count: done 3 cycles after accept, no start
        do_req(0, t);
        expect_done(t + 3, 4);
        at(t + 6);
        check("zero_level", bus.level, 0);
        check("zero_total", bus.issued_total, 4);
        next_cycle();

        // Five back-to-back requests into a 4-deep FIFO
        do_req(1, a);
        expect_ena(a + 3);   expect_done(a + 27, 5);
        expect_ena(a + 29);  expect_done(a + 53, 6);
        expect_ena(a + 55);  expect_done(a + 79, 7);
        expect_ena(a + 81);  expect_done(a + 105, 8);
        expect_ena(a + 107); expect_done(a + 131, 9);
        do_req(1, b);
        do_req(1, c);
        do_req(1, d);
        do_req(1, e);
        check("fill_acc_b", b, a + 1);
        check("fill_acc_c", c, a + 2);
        check("fill_acc_d", d, a + 3);
        check("fill_acc_e_after_pop", e, a + 27);
        @(negedge CLK);
        check("fill_level_full", bus.level, 4);
        check("fill_rdy_low", bus.request__RDY, 0);
        at(a + 134);
        check("fill_level_empty", bus.level, 0);
        check("fill_total", bus.issued_total, 9);
        next_cycle();

        // Watchdog abort, next request proceeds, then clear
        do_req(1, t);
        do_req(1, b);
        check("wd_acc_second", b, t + 1);
        expect_ena(t + 3);
        goto(t + 5);
        ds_stuck = 1'b1;
        at(t + 67);
        check("wd_error_before", bus.error, 0);
        next_cycle();
        ds_stuck = 1'b0;
        expect_ena(t + 70);
        expect_done(t + 94, 11);
        @(negedge CLK);
        check("wd_error_set", bus.error, 1);
        check("wd_level_dropped", bus.level, 1);
        at(t + 96);
        check("wd_error_sticky", bus.error, 1);
        next_cycle();
        bus.clearError__ENA = 1'b1;
        next_cycle();
        bus.clearError__ENA = 1'b0;
        @(negedge CLK);
        check("clear_error", bus.error, 0);
        next_cycle();

        // Clear in the same cycle as an abort: set wins
        do_req(1, t);
        expect_ena(t + 3);
        goto(t + 5);
        ds_stuck = 1'b1;
        goto(t + 67);
        bus.clearError__ENA = 1'b1;
        next_cycle();
        bus.clearError__ENA = 1'b0;
        ds_stuck = 1'b0;
        @(negedge CLK);
        check("clear_vs_abort_error", bus.error, 1);
        check("clear_vs_abort_level", bus.level, 0);
        check("clear_vs_abort_total", bus.issued_total, 12);
        next_cycle();

        // Asynchronous reset mid-WAIT with two queued behind
        do_req(2, t);
        do_req(2, b);
        do_req(2, c);
        expect_ena(t + 3);
        goto(t + 10);
        check("pre_rst_level", bus.level, 3);
        #2 nRST = 1'b0;
        #1;
        check("arst_ena",   bus.startSignal__ENA, 0);
        check("arst_done",  bus.done__ENA, 0);
        check("arst_error", bus.error, 0);
        check("arst_level", bus.level, 0);
        check("arst_total", bus.issued_total, 0);
        check("arst_rdy",   bus.request__RDY, 1);
        next_cycle();
        next_cycle();
        nRST = 1'b1;
        at(cyc + 60);
        check("post_rst_level", bus.level, 0);
        check("post_rst_total", bus.issued_total, 0);

        check("ena_queue_drained",  exp_ena_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
